// File: rtl/adder_bist_checker.sv
// Exhaustive self-test sweep for an external combinational adder slice: drives every {A,B,Cin},
// checks {Cout,S}, and reports pass/fail, error count and first failing vector. Optional: ADDER_BIST_LOOP_EN.
module adder_bist_checker #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               cin_o,
  input  logic [WIDTH-1:0]   s_i,
  input  logic               cout_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [2*WIDTH:0]   first_fail,
  output logic [1:0]         dbg_state_o
);

  localparam int VW = 2*WIDTH + 1;
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [VW-1:0]   vec_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     err_q;
  logic [VW-1:0]   ff_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic [WIDTH:0]  exp_sum;
  logic            mismatch;
  logic [15:0]     err_d;
  logic            last_vec;

  assign a_o         = vec_q[VW-1 -: WIDTH];
  assign b_o         = vec_q[WIDTH:1];
  assign cin_o       = vec_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_fail  = ff_q;
  assign dbg_state_o = state_q;

  assign exp_sum  = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
  assign mismatch = ({cout_i, s_i} != exp_sum);
  assign err_d    = (mismatch && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  assign last_vec = &vec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_DRIVE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_DRIVE: begin
          // done/pass are one-cycle pulses when sweeps run back to back
          done_q <= 1'b0;
          pass_q <= 1'b0;
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          // err_q saturates, so zero means no mismatch has been seen yet
          if (mismatch && (err_q == 16'd0)) ff_q <= vec_q;
          if (last_vec) begin
            done_q <= 1'b1;
            pass_q <= (err_d == 16'd0);
`ifdef ADDER_BIST_LOOP_EN
            if (start) begin
              vec_q   <= '0;
              state_q <= S_DRIVE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= S_DONE;
`endif
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker (WIDTH=1, SETTLE_CYCLES=2): fault-injecting full-adder model,
// table of sweep vectors, randomized fault masks checked against a reference sweep model.
module tb_adder_bist_checker;

  localparam int SWEEP_CYC = 24;

  logic       clk;
  logic       rst;
  logic       start;
  logic [0:0] a_o, b_o, s_i;
  logic       cin_o, cout_i;
  logic       busy, done, pass;
  logic [15:0] err_count;
  logic [2:0] first_fail;
  logic [1:0] dbg_state_o;

  int checks   = 0;
  int failures = 0;

  // fault model: 0 good, 1 cout stuck-at-0, 2 sum inverted, 3 per-vector xor mask
  int         mode;
  logic [1:0] mask [8];

  adder_bist_checker #(.WIDTH(1), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
    .s_i(s_i), .cout_i(cout_i),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail),
    .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] adder_resp(input int m, input int v);
    int   total;
    logic [1:0] good;
    total = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    good  = total[1:0];
    case (m)
      1:       return {1'b0, good[0]};
      2:       return {good[1], ~good[0]};
      3:       return good ^ mask[v];
      default: return good;
    endcase
  endfunction

  always_comb begin
    logic [1:0] r;
    r = adder_resp(mode, int'({a_o, b_o, cin_o}));
    cout_i = r[1];
    s_i    = r[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          m;
    logic [15:0] masks;
    int          exp_err;
    logic [2:0]  exp_first;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [8];

  // reference: sweep all 8 vectors, count wrong responses, note the first
  task automatic model_sweep(input int m, output int errs, output logic [2:0] first);
    errs  = 0;
    first = 3'd0;
    for (int v = 0; v < 8; v++) begin
      int truth;
      truth = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      if (int'(adder_resp(m, v)) != truth) begin
        if (errs == 0) first = 3'(v);
        errs++;
      end
    end
  endtask

  // start one sweep; optionally pulse start again when the driven vector equals pulse_vec
  task automatic run_sweep(input int pulse_vec, output int cycles);
    bit pulsed;
    pulsed = 0;
    cycles = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_drop_after_start", done, 0);
    while (!done && cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1;
      if (!pulsed && busy && int'({a_o, b_o, cin_o}) == pulse_vec) begin
        start  = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    foreach (mask[i]) mask[i] = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_cin", cin_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_fail, 0);
    @(negedge clk) rst = 1'b0;

    tbl[0] = '{0, 16'h0, 0, 3'b000, 1'b1};
    tbl[1] = '{1, 16'h0, 4, 3'b011, 1'b0};
    tbl[2] = '{2, 16'h0, 8, 3'b000, 1'b0};
    for (int i = 3; i < 8; i++) begin
      tbl[i].m     = 3;
      tbl[i].masks = 16'($urandom_range(0, 16'hFFFF));
      for (int v = 0; v < 8; v++) mask[v] = tbl[i].masks[2*v +: 2];
      model_sweep(3, tbl[i].exp_err, tbl[i].exp_first);
      tbl[i].exp_pass = (tbl[i].exp_err == 0);
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mode = tbl[i].m;
      for (int v = 0; v < 8; v++) mask[v] = tbl[i].masks[2*v +: 2];
      run_sweep(-1, cyc);
      chk($sformatf("t%0d_latency", i), cyc, SWEEP_CYC);
      chk($sformatf("t%0d_err", i), err_count, tbl[i].exp_err);
      chk($sformatf("t%0d_first", i), first_fail, tbl[i].exp_first);
      chk($sformatf("t%0d_pass", i), pass, tbl[i].exp_pass);
      chk($sformatf("t%0d_busy", i), busy, 0);
      chk($sformatf("t%0d_hold_vec", i), {a_o, b_o, cin_o}, 3'b111);
    end

    // start re-asserted at vector 3 is ignored
    @(negedge clk) mode = 1;
    run_sweep(3, cyc);
    chk("restart_ignored_latency", cyc, SWEEP_CYC);
    chk("restart_ignored_err", err_count, 4);
    chk("restart_ignored_first", first_fail, 3'b011);

    // reset during DRIVE of vector 5
    @(negedge clk) mode = 2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!(int'({a_o, b_o, cin_o}) == 5 && dbg_state_o == 2'd1) && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("reach_vec5", {a_o, b_o, cin_o}, 3'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_vec", {a_o, b_o, cin_o}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_first", first_fail, 0);
    rst  = 1'b0;
    mode = 0;
    run_sweep(-1, cyc);
    chk("post_rst_latency", cyc, SWEEP_CYC);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);

`ifdef ADDER_BIST_LOOP_EN
    @(negedge clk) mode = 1;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 48; c++) begin
      @(posedge clk);
      #1;
      if (c == 24) chk("loop_done_24", done, 1);
      if (c == 25) chk("loop_done_25", done, 0);
      if (c == 47) chk("loop_done_47", done, 0);
      if (c == 48) begin
        chk("loop_done_48", done, 1);
        chk("loop_err_48", err_count, 8);
        chk("loop_busy_48", busy, 1);
        chk("loop_first_48", first_fail, 3'b011);
      end
    end
    start = 1'b0;
    cyc = 0;
    while (!(done && !busy) && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("loop_final_done", done && !busy, 1);
    chk("loop_final_err", err_count, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
